// File: rtl/hb_interp_chain_if.sv
// Sample-stream bundle for the half-band interpolation chain: output-rate strobe,
// input capture marker, and input/output samples.
interface hb_interp_chain_if #(
    parameter int WIDTH = 18
);
    logic                    out_en;
    logic                    in_take;
    logic signed [WIDTH-1:0] data_in;
    logic signed [WIDTH-1:0] data_out;
    logic                    out_valid;

    modport master (
        output out_en,
        output data_in,
        input  in_take,
        input  data_out,
        input  out_valid
    );

    modport slave (
        input  out_en,
        input  data_in,
        output in_take,
        output data_out,
        output out_valid
    );
endinterface

// File: rtl/hb_interp_chain.sv
// Chain of NUM_STAGES x2 half-band interpolators, all timed from one output-rate strobe.
// Each stage can run as a [-1 0 9 16 9 0 -1]/16 half-band or as a zero-order hold.
module hb_interp_chain #(
    parameter int WIDTH      = 18,
    parameter int NUM_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    hb_interp_chain_if.slave      bus,
    input  logic [NUM_STAGES-1:0] mode,
    input  logic                  clear_ovf,
    output logic                  ovf
);

    localparam int AW = WIDTH + 6;
    localparam logic signed [AW-1:0] SAT_MAX = AW'((1 << (WIDTH-1)) - 1);
    localparam logic signed [AW-1:0] SAT_MIN = AW'(-(1 << (WIDTH-1)));
    localparam logic signed [AW-1:0] ROUND   = AW'(8);

    logic [NUM_STAGES-1:0]       phase;
    logic [NUM_STAGES-1:0]       mode_q;
    logic [NUM_STAGES-1:0]       sat_hit;
    logic [NUM_STAGES*WIDTH-1:0] y_bus;
    logic                        take;

    assign take         = bus.out_en && (phase == '0);
    assign bus.in_take  = take;
    assign bus.data_out = y_bus[NUM_STAGES*WIDTH-1 -: WIDTH];

    // Mode is latched only at frame start so a stage never switches mid-frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase         <= '0;
            mode_q        <= '0;
            bus.out_valid <= 1'b0;
            ovf           <= 1'b0;
        end else begin
            bus.out_valid <= bus.out_en;
            if (bus.out_en) phase <= phase + NUM_STAGES'(1);
            if (take) mode_q <= mode;
            if (|sat_hit) ovf <= 1'b1;
            else if (clear_ovf) ovf <= 1'b0;
        end
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        localparam int LOW = NUM_STAGES - 1 - k;

        logic signed [WIDTH-1:0] x0, x1, x2, x3, y;
        logic signed [WIDTH-1:0] stage_in, sat_val;
        logic signed [AW-1:0]    sum_c, sum_o, acc, scaled;
        logic                    adv, odd, clip;

        // Stage k runs at 2^(k+1) times the input rate: it advances when the low phase bits are clear.
        if (LOW == 0) begin : g_adv_all
            assign adv = bus.out_en;
        end else begin : g_adv_sub
            assign adv = bus.out_en && (phase[LOW-1:0] == '0);
        end
        assign odd = phase[LOW];

        if (k == 0) begin : g_in_first
            assign stage_in = bus.data_in;
        end else begin : g_in_chain
            assign stage_in = y_bus[(k-1)*WIDTH +: WIDTH];
        end

        always_comb begin
            sum_c   = {{6{x1[WIDTH-1]}}, x1} + {{6{x2[WIDTH-1]}}, x2};
            sum_o   = {{6{x0[WIDTH-1]}}, x0} + {{6{x3[WIDTH-1]}}, x3};
            acc     = (sum_c <<< 3) + sum_c - sum_o + ROUND;
            scaled  = acc >>> 4;
            clip    = 1'b0;
            sat_val = scaled[WIDTH-1:0];
            if (scaled > SAT_MAX) begin
                sat_val = SAT_MAX[WIDTH-1:0];
                clip    = 1'b1;
            end else if (scaled < SAT_MIN) begin
                sat_val = SAT_MIN[WIDTH-1:0];
                clip    = 1'b1;
            end
        end

        assign sat_hit[k] = adv && odd && !mode_q[k] && clip;

        // Even phase pushes a new sample and emits the centre tap; odd phase interpolates or holds.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                x0 <= '0;
                x1 <= '0;
                x2 <= '0;
                x3 <= '0;
                y  <= '0;
            end else if (adv) begin
                if (!odd) begin
                    x3 <= x2;
                    x2 <= x1;
                    x1 <= x0;
                    x0 <= stage_in;
                    y  <= x1;
                end else if (mode_q[k]) begin
                    y <= x2;
                end else begin
                    y <= sat_val;
                end
            end
        end

        assign y_bus[k*WIDTH +: WIDTH] = y;
    end

endmodule

// File: tb/tb_hb_interp_chain.sv
// Bench for hb_interp_chain: one N=1 and one N=2 instance checked against an
// integer reference model of the interpolation rules plus directed constants.
module tb_hb_interp_chain;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hb_interp_chain_if #(.WIDTH(18)) bus1 ();
    hb_interp_chain_if #(.WIDTH(18)) bus2 ();

    logic [0:0] mode1;
    logic [1:0] mode2;
    logic       clr1, clr2, ovf1, ovf2;

    hb_interp_chain #(.WIDTH(18), .NUM_STAGES(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .mode(mode1), .clear_ovf(clr1), .ovf(ovf1)
    );
    hb_interp_chain #(.WIDTH(18), .NUM_STAGES(2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2), .mode(mode2), .clear_ovf(clr2), .ovf(ovf2)
    );

    int errors = 0;
    int checks = 0;
    int mx[2][4][4];
    int my[2][4];
    int mp[2];
    int mmode[2];
    bit movf[2];
    logic last_take;

    function automatic int nst(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic int fdiv16(input int v);
        int q;
        q = v / 16;
        if (v < 0 && (v % 16) != 0) q = q - 1;
        return q;
    endfunction

    task automatic check_output(input string tag, input logic signed [31:0] obs,
                                input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) begin
                my[d][k] = 0;
                for (int t = 0; t < 4; t++) mx[d][k][t] = 0;
            end
            mp[d]    = 0;
            mmode[d] = 0;
            movf[d]  = 1'b0;
        end
    endtask

    // Reference: stage k advances on strobes where phase mod 2^(N-1-k) is 0, chained on pre-edge outputs.
    task automatic model_cycle(input int d, input bit en, input int din, input int modev, input bit clr);
        int n, pv, low, inv, v;
        int prevy[4];
        bit set;
        n   = nst(d);
        set = 1'b0;
        if (en) begin
            pv    = mp[d];
            prevy = my[d];
            if (pv == 0) mmode[d] = modev & ((1 << n) - 1);
            for (int k = 0; k < n; k++) begin
                low = n - 1 - k;
                if (pv % (1 << low) == 0) begin
                    if (k == 0) inv = din;
                    else inv = prevy[k-1];
                    if (((pv >> low) & 1) == 0) begin
                        mx[d][k][3] = mx[d][k][2];
                        mx[d][k][2] = mx[d][k][1];
                        mx[d][k][1] = mx[d][k][0];
                        mx[d][k][0] = inv;
                        my[d][k]    = mx[d][k][2];
                    end else if (((mmode[d] >> k) & 1) == 1) begin
                        my[d][k] = mx[d][k][2];
                    end else begin
                        v = 9 * (mx[d][k][1] + mx[d][k][2]) - (mx[d][k][0] + mx[d][k][3]) + 8;
                        v = fdiv16(v);
                        if (v > 131071) begin
                            v   = 131071;
                            set = 1'b1;
                        end else if (v < -131072) begin
                            v   = -131072;
                            set = 1'b1;
                        end
                        my[d][k] = v;
                    end
                end
            end
            mp[d] = (pv + 1) % (1 << n);
        end
        if (set) movf[d] = 1'b1;
        else if (clr) movf[d] = 1'b0;
    endtask

    task automatic apply_stimulus(input int d, input bit en, input int din, input int modev, input bit clr);
        logic obs_take;
        bus1.out_en  = (d == 0) && en;
        bus2.out_en  = (d == 1) && en;
        bus1.data_in = 18'(din);
        bus2.data_in = 18'(din);
        mode1        = 1'(modev);
        mode2        = 2'(modev);
        clr1         = (d == 0) && clr;
        clr2         = (d == 1) && clr;
        #1;
        obs_take  = (d == 0) ? bus1.in_take : bus2.in_take;
        last_take = obs_take;
        check_output("in_take", obs_take, (en && mp[d] == 0));
        @(posedge clk);
        #1;
        model_cycle(d, en, din, modev, clr);
        if (d == 0) begin
            check_output("data_out1", bus1.data_out, my[0][0]);
            check_output("out_valid1", bus1.out_valid, en);
            check_output("ovf1", ovf1, movf[0]);
        end else begin
            check_output("data_out2", bus2.data_out, my[1][1]);
            check_output("out_valid2", bus2.out_valid, en);
            check_output("ovf2", ovf2, movf[1]);
        end
    endtask

    function automatic int rand_sample();
        return int'($urandom_range(0, 262143)) - 131072;
    endfunction

    initial begin
        int imp_exp[10] = '{0, -100, 0, 900, 1600, 900, 0, -100, 0, 0};
        int sat_in[4]   = '{-131072, 131071, 131071, -131072};
        int cnt100, cnt200, takes;

        reset        = 1'b0;
        bus1.out_en  = 1'b0;
        bus2.out_en  = 1'b0;
        bus1.data_in = '0;
        bus2.data_in = '0;
        mode1        = '0;
        mode2        = '0;
        clr1         = 1'b0;
        clr2         = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_data_out1", bus1.data_out, 0);
        check_output("rst_data_out2", bus2.data_out, 0);
        check_output("rst_out_valid1", bus1.out_valid, 0);
        check_output("rst_out_valid2", bus2.out_valid, 0);
        check_output("rst_ovf1", ovf1, 0);
        check_output("rst_ovf2", ovf2, 0);
        reset = 1'b1;
        apply_stimulus(0, 1'b0, 0, 0, 1'b0);

        $display("[TB] impulse, N=1");
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) apply_stimulus(0, 1'b1, (i == 0) ? 1600 : 0, 0, 1'b0);
            else apply_stimulus(0, 1'b1, int'($urandom), 0, 1'b0);
            check_output("impulse", bus1.data_out, imp_exp[i]);
        end

        $display("[TB] saturation, N=1");
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                apply_stimulus(0, 1'b1, sat_in[i], 0, r == 1);
                apply_stimulus(0, 1'b1, int'($urandom), 0, r == 1);
            end
            if (r == 0) begin
                check_output("sat_clamp", bus1.data_out, 131071);
                check_output("sat_ovf", ovf1, 1);
                apply_stimulus(0, 1'b0, 0, 0, 1'b1);
                check_output("ovf_clear", ovf1, 0);
            end else begin
                check_output("ovf_set_wins", ovf1, 1);
                apply_stimulus(0, 1'b0, 0, 0, 1'b1);
            end
        end

        $display("[TB] dc, N=2");
        for (int i = 0; i < 32; i++) begin
            apply_stimulus(1, 1'b1, -5000, 0, 1'b0);
            if (i >= 20) begin
                check_output("dc_level", bus2.data_out, -5000);
                check_output("dc_ovf", ovf2, 0);
            end
        end

        $display("[TB] hold, N=2");
        cnt100 = 0;
        cnt200 = 0;
        for (int f = 0; f < 7; f++) begin
            for (int ph = 0; ph < 4; ph++) begin
                if (ph == 0) apply_stimulus(1, 1'b1, (f == 0) ? 100 : (f == 1) ? 200 : 300, 3, 1'b0);
                else apply_stimulus(1, 1'b1, int'($urandom), int'($urandom_range(0, 3)), 1'b0);
                if (bus2.data_out == 18'sd100) cnt100++;
                if (bus2.data_out == 18'sd200) cnt200++;
            end
        end
        check_output("hold_count100", cnt100, 4);
        check_output("hold_count200", cnt200, 4);

        $display("[TB] random, N=2");
        for (int i = 0; i < 120; i++) begin
            apply_stimulus(1, $urandom_range(0, 3) != 0, rand_sample(),
                           int'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
        end

        $display("[TB] reset mid-frame, N=2");
        for (int i = 0; i < 4 && mp[1] != 2; i++) begin
            apply_stimulus(1, 1'b1, rand_sample(), 0, 1'b0);
        end
        check_output("pre_reset_phase", mp[1], 2);
        bus2.out_en = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_output("midrst_data_out", bus2.data_out, 0);
        check_output("midrst_out_valid", bus2.out_valid, 0);
        check_output("midrst_ovf", ovf2, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        apply_stimulus(1, 1'b0, 0, 0, 1'b0);
        takes = 0;
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(1, 1'b1, rand_sample(), 0, 1'b0);
            if (i == 0) check_output("first_take", last_take, 1);
            if (last_take === 1'b1) takes++;
        end
        check_output("take_ratio", takes, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
